// File: rtl/selector_juego_if.sv
// ---------------------------------------------------------------------------
// selector_juego_if
// Bundles the game-selector user inputs and the selection/reset outputs.
//   btn_next, btn_prev, btn_restart : raw asynchronous buttons, active-high
//   i_direct_sel [6:0]              : clk-synchronous one-hot direct-select pulse
//   o_gamesel    [6:0]              : registered one-hot game select
//   o_chip_reset                    : active-high reset to the AY core
//   o_busy                          : selector is holding the core in reset
// Modports: master drives the inputs (keyboard/buttons side), slave is the
// selector itself.
// ---------------------------------------------------------------------------
interface selector_juego_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_restart;
    logic [6:0] i_direct_sel;
    logic [6:0] o_gamesel;
    logic       o_chip_reset;
    logic       o_busy;

    modport master (
        output btn_next, btn_prev, btn_restart, i_direct_sel,
        input  o_gamesel, o_chip_reset, o_busy
    );

    modport slave (
        input  btn_next, btn_prev, btn_restart, i_direct_sel,
        output o_gamesel, o_chip_reset, o_busy
    );
endinterface

// File: rtl/selector_juego.sv
// ---------------------------------------------------------------------------
// selector_juego
// Game selection sequencer for the AY-3-8500 pong core. Raw buttons are
// synchronised and debounced; their press edges, together with one-cycle
// direct-select pulses, change a one-hot game select. Every change or restart
// holds the core in reset for RESET_CYCLES cycles, during which new events
// are dropped.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   bus    : selector_juego_if.slave (buttons, direct select, outputs)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles before a button level is accepted (>=2)
//   RESET_CYCLES    : cycles o_chip_reset stays high per (re)start (>=1)
//   SKIP_EXTRA      : 1 = next/prev cycling skips the extra game (bit 6)
// ---------------------------------------------------------------------------
module selector_juego #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int RESET_CYCLES    = 1024,
    parameter int SKIP_EXTRA      = 1
) (
    input  logic             clk,
    input  logic             reset,
    selector_juego_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RC_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RESET_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Button index: 0 = next, 1 = prev, 2 = restart
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stable;
    logic [2:0]      ev;
    logic [DB_W-1:0] db_cnt [3];

    logic [0:0]      state;
    logic [RC_W-1:0] hold_cnt;
    logic [6:0]      gamesel;
    logic            chip_reset;
    logic            busy;

    logic            do_action;
    logic [6:0]      next_sel;

    function automatic logic is_onehot(input logic [6:0] d);
        return (d != 7'd0) && ((d & (d - 7'd1)) == 7'd0);
    endfunction

    // Forward step; the wrap point depends on whether the extra game is in the cycle.
    // From the extra game itself, forward always lands on tennis.
    function automatic logic [6:0] rot_next(input logic [6:0] g);
        if (g[6] || ((SKIP_EXTRA != 0) && g[5]))
            return 7'b0000001;
        return {g[5:0], 1'b0};
    endfunction

    // Backward step; from the extra game a plain shift already lands on rifle2.
    function automatic logic [6:0] rot_prev(input logic [6:0] g);
        if (g[0])
            return (SKIP_EXTRA != 0) ? 7'b0100000 : 7'b1000000;
        return {1'b0, g[6:1]};
    endfunction

    assign btn_raw = {bus.btn_restart, bus.btn_prev, bus.btn_next};

    // Synchroniser and debouncer; ev pulses for one cycle on an accepted press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            ev     <= '0;
            for (int i = 0; i < 3; i++)
                db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                ev[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                    ev[i]     <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // One action per IDLE cycle: direct select > restart > next alone > prev alone.
    // Next and prev together cancel out.
    always_comb begin
        do_action = 1'b0;
        next_sel  = gamesel;
        if (is_onehot(bus.i_direct_sel)) begin
            do_action = 1'b1;
            next_sel  = bus.i_direct_sel;
        end else if (ev[2]) begin
            do_action = 1'b1;
        end else if (ev[0] && !ev[1]) begin
            do_action = 1'b1;
            next_sel  = rot_next(gamesel);
        end else if (ev[1] && !ev[0]) begin
            do_action = 1'b1;
            next_sel  = rot_prev(gamesel);
        end
    end

    // Selection FSM; hold_cnt counts down so the core sees exactly RESET_CYCLES of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HOLD;
            hold_cnt   <= RC_MAX;
            gamesel    <= 7'b0000001;
            chip_reset <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (do_action) begin
                        gamesel    <= next_sel;
                        hold_cnt   <= RC_MAX;
                        chip_reset <= 1'b1;
                        busy       <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        chip_reset <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_gamesel    = gamesel;
    assign bus.o_chip_reset = chip_reset;
    assign bus.o_busy       = busy;

endmodule
